merge_arbiter_ctrl: RTL and testbench

MERGE_ARBITER_CTRL -- requirements
Module: merge_arbiter_ctrl

---
 rtl/merge_arb_pkg.sv | 26 ++
 rtl/merge_out_reg.sv | 33 +++
 rtl/merge_arbiter_ctrl.sv | 117 +++++++++++
 tb/tb_merge_arbiter_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/merge_arb_pkg.sv
// Shared types and constants for the two-lane merge arbiter.
// Holds the arbitration state encoding, the lane-mask command codes and the lane indices.
package merge_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_LOW  = 2'd1,
    ST_GRANT_HIGH = 2'd2
  } arb_state_e;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_LOW  = 2'b01;
  localparam logic [1:0] CMD_HIGH = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;

  localparam logic LANE_LOW  = 1'b0;
  localparam logic LANE_HIGH = 1'b1;

  // Wide enough for the largest allowed burst limit (15).
  localparam int BURST_W = 4;

  function automatic arb_state_e grant_state(input logic lane);
    return (lane == LANE_HIGH) ? ST_GRANT_HIGH : ST_GRANT_LOW;
  endfunction

endpackage

// File: rtl/merge_out_reg.sv
// Output register stage of the merge arbiter: captures data and source lane on load,
// clears the valid flag when the held beat is taken without a replacement.
module merge_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drain,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic                  d_src,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  src
);

  // NOTE: the data register is reset too, so a reset mid-burst discards the held beat
  // instead of leaving stale data visible on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      src   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      src   <= d_src;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/merge_arbiter_ctrl.sv
// Two-lane merge arbiter: picks one eligible lane per cycle with burst-limited
// round-robin fairness and feeds a single registered output stage.
module merge_arbiter_ctrl
  import merge_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  output logic [1:0]              o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data_bus,
  output logic                    o_src,
  input  logic                    i_ready,
  input  logic                    i_en,
  input  logic [1:0]              i_cmd
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  arb_state_e             state;
  logic [BURST_W-1:0]     burst_cnt;
  logic                   last_src;

  logic [1:0]             elig;
  logic                   space;
  logic                   load;
  logic                   hold_lane;
  logic                   sel_valid;
  logic                   sel_lane;
  logic                   sel_cont;
  logic [DATA_WIDTH-1:0]  sel_data;

  assign elig  = i_valid & i_cmd;
  assign space = !o_valid || i_ready;
  // Reset gating keeps o_ready at 00 while rst is high, even with requests present.
  assign load  = i_en && space && sel_valid && !rst;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_lane  = LANE_LOW;
    sel_cont  = 1'b0;
    hold_lane = (state == ST_GRANT_HIGH);
    unique case (state)
      ST_IDLE: begin
        if (elig == CMD_BOTH) begin
          sel_valid = 1'b1;
          sel_lane  = ~last_src;
        end else if (elig[LANE_LOW]) begin
          sel_valid = 1'b1;
          sel_lane  = LANE_LOW;
        end else if (elig[LANE_HIGH]) begin
          sel_valid = 1'b1;
          sel_lane  = LANE_HIGH;
        end
      end
      ST_GRANT_LOW, ST_GRANT_HIGH: begin
        // Keep the holder until its burst is used up, but only while the other lane waits.
        if (elig[hold_lane] && (burst_cnt < MAX_B || !elig[~hold_lane])) begin
          sel_valid = 1'b1;
          sel_lane  = hold_lane;
          sel_cont  = 1'b1;
        end else if (elig[~hold_lane]) begin
          sel_valid = 1'b1;
          sel_lane  = ~hold_lane;
        end
      end
      default: begin
        sel_valid = 1'b0;
      end
    endcase
  end

  assign sel_data = sel_lane ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                             : i_data_bus[DATA_WIDTH-1:0];
  assign o_ready  = load ? (sel_lane ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees
  // the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      last_src  <= LANE_HIGH;
    end else if (load) begin
      state    <= grant_state(sel_lane);
      last_src <= sel_lane;
      if (!sel_cont) begin
        burst_cnt <= BURST_W'(1);
      end else if (burst_cnt < MAX_B) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end else if (i_en && space && (elig == CMD_NONE) && (state != ST_IDLE)) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end
  end

  merge_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .drain  (i_ready),
    .d_data (sel_data),
    .d_src  (sel_lane),
    .valid  (o_valid),
    .data   (o_data_bus),
    .src    (o_src)
  );

endmodule

// File: tb/tb_merge_arbiter_ctrl.sv
// Directed table-driven bench for merge_arbiter_ctrl (DATA_WIDTH=32, MAX_BURST=4),
// with hand-written reset sequences around the vector table.
module tb_merge_arbiter_ctrl;

  localparam int DW = 32;
  localparam int NV = 29;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic [1:0]    o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data_bus;
  logic          o_src;
  logic          i_ready;
  logic          i_en;
  logic [1:0]    i_cmd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  cmd;
    logic        en;
    logic        rdy;
    logic [1:0]  exp_ordy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_src;
  } vec_t;

  vec_t vecs [NV];

  merge_arbiter_ctrl #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .o_src      (o_src),
    .i_ready    (i_ready),
    .i_en       (i_en),
    .i_cmd      (i_cmd)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int i, input logic [1:0] valid, input logic [1:0] cmd,
                              input logic en, input logic rdy, input logic [1:0] ordy,
                              input logic ev, input logic [31:0] ed, input logic es);
    vec_t v;
    v.valid = valid;
    v.lo = 32'hA000_0000 | i;
    v.hi = 32'hB000_0000 | i;
    v.cmd = cmd;
    v.en = en;
    v.rdy = rdy;
    v.exp_ordy = ordy;
    v.exp_v = ev;
    v.exp_d = ed;
    v.exp_src = es;
    return v;
  endfunction

  // Called right after a rising edge (+1): drive, check o_ready, clock, check registers.
  task automatic step(input string tag, input vec_t v);
    i_valid    = v.valid;
    i_data_bus = {v.hi, v.lo};
    i_cmd      = v.cmd;
    i_en       = v.en;
    i_ready    = v.rdy;
    #1;
    check({tag, " o_ready"}, {30'd0, o_ready}, {30'd0, v.exp_ordy});
    @(posedge clk);
    #1;
    check({tag, " o_valid"}, {31'd0, o_valid}, {31'd0, v.exp_v});
    check({tag, " o_data"}, o_data_bus, v.exp_d);
    check({tag, " o_src"}, {31'd0, o_src}, {31'd0, v.exp_src});
  endtask

  initial begin
    vec_t v;
    // Burst alternation: 4 low, 4 high, then low again.
    vecs[0]  = mk(0,  2'b11, 2'b11, 1, 1, 2'b01, 1, 32'h1111_1111, 0);
    vecs[0].lo = 32'h1111_1111;
    vecs[0].hi = 32'h2222_2222;
    vecs[1]  = mk(1,  2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0001, 0);
    vecs[2]  = mk(2,  2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0002, 0);
    vecs[3]  = mk(3,  2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0003, 0);
    vecs[4]  = mk(4,  2'b11, 2'b11, 1, 1, 2'b10, 1, 32'hB000_0004, 1);
    vecs[5]  = mk(5,  2'b11, 2'b11, 1, 1, 2'b10, 1, 32'hB000_0005, 1);
    vecs[6]  = mk(6,  2'b11, 2'b11, 1, 1, 2'b10, 1, 32'hB000_0006, 1);
    vecs[7]  = mk(7,  2'b11, 2'b11, 1, 1, 2'b10, 1, 32'hB000_0007, 1);
    vecs[8]  = mk(8,  2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0008, 0);
    // Backpressure: held beat stays, no accepts, then transfer plus new load.
    vecs[9]  = mk(9,  2'b11, 2'b11, 1, 0, 2'b00, 1, 32'hA000_0008, 0);
    vecs[10] = mk(10, 2'b11, 2'b11, 1, 0, 2'b00, 1, 32'hA000_0008, 0);
    vecs[11] = mk(11, 2'b11, 2'b11, 1, 0, 2'b00, 1, 32'hA000_0008, 0);
    vecs[12] = mk(12, 2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_000C, 0);
    // Lane mask: high only, then switch to low only mid-burst.
    vecs[13] = mk(13, 2'b11, 2'b10, 1, 1, 2'b10, 1, 32'hB000_000D, 1);
    vecs[14] = mk(14, 2'b11, 2'b10, 1, 1, 2'b10, 1, 32'hB000_000E, 1);
    vecs[15] = mk(15, 2'b11, 2'b01, 1, 1, 2'b01, 1, 32'hA000_000F, 0);
    // Drain to IDLE; tie in IDLE goes to the lane that did not load last.
    vecs[16] = mk(16, 2'b00, 2'b11, 1, 1, 2'b00, 0, 32'hA000_000F, 0);
    vecs[17] = mk(17, 2'b11, 2'b11, 1, 1, 2'b10, 1, 32'hB000_0011, 1);
    // Enable gap after 2 low loads: burst count frozen, 2 more low loads follow.
    vecs[18] = mk(18, 2'b01, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0012, 0);
    vecs[19] = mk(19, 2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0013, 0);
    vecs[20] = mk(20, 2'b11, 2'b11, 0, 1, 2'b00, 0, 32'hA000_0013, 0);
    vecs[21] = mk(21, 2'b11, 2'b11, 0, 1, 2'b00, 0, 32'hA000_0013, 0);
    vecs[22] = mk(22, 2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0016, 0);
    vecs[23] = mk(23, 2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_0017, 0);
    vecs[24] = mk(24, 2'b11, 2'b11, 1, 1, 2'b10, 1, 32'hB000_0018, 1);
    // Mask none returns to IDLE; next tie goes low.
    vecs[25] = mk(25, 2'b11, 2'b00, 1, 1, 2'b00, 0, 32'hB000_0018, 1);
    vecs[26] = mk(26, 2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hA000_001A, 0);
    vecs[27] = mk(27, 2'b10, 2'b11, 1, 1, 2'b10, 1, 32'hB000_001B, 1);
    vecs[28] = mk(28, 2'b11, 2'b11, 1, 1, 2'b10, 1, 32'hB000_001C, 1);

    // Reset with requests present: outputs cleared and no accepts.
    rst        = 1'b1;
    i_valid    = 2'b11;
    i_data_bus = {32'h2222_2222, 32'h1111_1111};
    i_cmd      = 2'b11;
    i_en       = 1'b1;
    i_ready    = 1'b1;
    #3;
    check("reset o_ready", {30'd0, o_ready}, 32'd0);
    check("reset o_valid", {31'd0, o_valid}, 32'd0);
    check("reset o_data", o_data_bus, 32'd0);
    check("reset o_src", {31'd0, o_src}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) step($sformatf("v%0d", i), vecs[i]);

    // Asynchronous reset mid-burst (grant high, burst 2) with a beat held.
    rst = 1'b1;
    #1;
    check("midrst o_valid", {31'd0, o_valid}, 32'd0);
    check("midrst o_data", o_data_bus, 32'd0);
    check("midrst o_src", {31'd0, o_src}, 32'd0);
    check("midrst o_ready", {30'd0, o_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Restart from IDLE: the tie goes to the low lane despite the prior high grant.
    v = mk(0, 2'b11, 2'b11, 1, 1, 2'b01, 1, 32'hC000_0000, 0);
    v.lo = 32'hC000_0000;
    v.hi = 32'hD000_0000;
    step("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
